// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, read-allocate cache controller with a req/ack backing-memory port.
// Define CACHE_STATS_EN to build the read hit/miss counters; otherwise hit_cnt/miss_cnt read as 0.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a request
//   FILL  | read miss, fetching the word from backing memory
//   WRITE | write-through in progress on backing memory
//   RESP  | one-cycle response; a new request may be accepted here
module dm_cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 4,
    parameter int IDX_W  = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              resp_valid,
    output logic [DATA_W-1:0] q,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req_hit;
    logic [IDX_W-1:0] cur_idx;
    logic [TAG_W-1:0] cur_tag;
    logic             cur_hit;
    logic             accept;

    assign req_idx = addr[IDX_W-1:0];
    assign req_tag = addr[ADDR_W-1:IDX_W];
    assign req_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    // mem_addr holds the in-flight request address, so it doubles as the latched index/tag.
    assign cur_idx = mem_addr[IDX_W-1:0];
    assign cur_tag = mem_addr[ADDR_W-1:IDX_W];
    assign cur_hit = valid[cur_idx] && (tag_mem[cur_idx] == cur_tag);

    assign accept = req && ((state == IDLE) || (state == RESP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            q          <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    state <= IDLE;
                    if (req) begin
                        if (wr) begin
                            state     <= WRITE;
                            busy      <= 1'b1;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= data;
                        end else if (req_hit) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            q          <= data_mem[req_idx];
                        end else begin
                            state    <= FILL;
                            busy     <= 1'b1;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= addr;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid[cur_idx] <= 1'b1;
                        q              <= mem_rdata;
                        mem_req        <= 1'b0;
                        busy           <= 1'b0;
                        resp_valid     <= 1'b1;
                        state          <= RESP;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        busy       <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; validity alone gates their use.
    always_ff @(posedge clk) begin
        if ((state == FILL) && mem_ack) begin
            tag_mem[cur_idx]  <= cur_tag;
            data_mem[cur_idx] <= mem_rdata;
        end else if ((state == WRITE) && mem_ack && cur_hit) begin
            data_mem[cur_idx] <= mem_wdata;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept && !wr) begin
            if (req_hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign hit_cnt       = '0;
    assign miss_cnt      = '0;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: a table of single transactions plus hand-written
// sequences for back-to-back hits, ignored requests while busy, and reset mid-fill.
module tb_dm_cache_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LINES  = 4;
    localparam int BUDGET = 20;

`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              resp_valid;
    logic [DATA_W-1:0] q;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    int checks = 0;
    int errors = 0;

    dm_cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .wr         (wr),
        .addr       (addr),
        .data       (data),
        .busy       (busy),
        .resp_valid (resp_valid),
        .q          (q),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    // wr, addr, data (write data or memory return), ack delay, expects memory op,
    // expected q, response latency, cumulative hit/miss counts.
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          n;
        logic        mem_op;
        logic [31:0] exp_q;
        int          exp_lat;
        int          exp_hc;
        int          exp_mc;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mkv(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input int n, input logic op, input logic [31:0] eq,
                                 input int lat, input int hc, input int mc);
        vec_t v;
        v.wr = w; v.addr = a; v.data = d; v.n = n; v.mem_op = op;
        v.exp_q = eq; v.exp_lat = lat; v.exp_hc = hc; v.exp_mc = mc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name, input int hc, input int mc);
        check({name, " hit_cnt"},  {32'd0, hit_cnt},  STATS ? 64'(hc) : 64'd0);
        check({name, " miss_cnt"}, {32'd0, miss_cnt}, STATS ? 64'(mc) : 64'd0);
    endtask

    // Acts as the backing memory: acks v.n cycles after mem_req rises.
    task automatic run_txn(input vec_t v, input string name);
        int k, first_req, wait_cyc, lat;
        bit resp_seen, mem_bad, busy_bad;
        logic [DATA_W-1:0] got_q;
        k = 1; first_req = -1; wait_cyc = 0; lat = -1;
        resp_seen = 0; mem_bad = 0; busy_bad = 0; got_q = '0;
        @(posedge clk); #1;
        req = 1'b1; wr = v.wr; addr = v.addr; data = v.data;
        @(posedge clk); #1;
        req = 1'b0;
        while (!resp_seen && k <= BUDGET) begin
            @(negedge clk);
            if (mem_req) begin
                if (first_req < 0) first_req = k;
                if (mem_addr !== v.addr || mem_we !== v.wr || (v.wr && mem_wdata !== v.data))
                    mem_bad = 1;
                if (busy !== 1'b1) busy_bad = 1;
                if (k == first_req + v.n) begin
                    mem_ack = 1'b1;
                    mem_rdata = v.wr ? 32'hFFFF_FFFF : v.data;
                end else begin
                    wait_cyc++;
                end
            end
            if (resp_valid) begin
                resp_seen = 1;
                lat = k;
                got_q = q;
                if (busy !== 1'b0) busy_bad = 1;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            k++;
        end
        check({name, " resp_seen"}, 64'(resp_seen), 64'd1);
        check({name, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({name, " q"}, {32'd0, got_q}, {32'd0, v.exp_q});
        check({name, " mem_op"}, 64'(first_req >= 0), 64'(v.mem_op));
        check({name, " mem_wait"}, 64'(wait_cyc), v.mem_op ? 64'(v.n) : 64'd0);
        check({name, " mem_stable"}, 64'(mem_bad), 64'd0);
        check({name, " busy"}, 64'(busy_bad), 64'd0);
        check_cnt(name, v.exp_hc, v.exp_mc);
        @(negedge clk);
        check({name, " single_pulse"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        int pulses, rises;
        bit prev, bad;
        logic [DATA_W-1:0] got_q;

        vecs[0]  = mkv(0, 32'h10, 32'hDEADBEEF, 3, 1, 32'hDEADBEEF, 5, 0, 1);
        vecs[1]  = mkv(0, 32'h10, 32'h0,        0, 0, 32'hDEADBEEF, 1, 1, 1);
        vecs[2]  = mkv(1, 32'h10, 32'h12345678, 2, 1, 32'hDEADBEEF, 4, 1, 1);
        vecs[3]  = mkv(0, 32'h10, 32'h0,        0, 0, 32'h12345678, 1, 2, 1);
        vecs[4]  = mkv(0, 32'h14, 32'hCAFEF00D, 1, 1, 32'hCAFEF00D, 3, 2, 2);
        vecs[5]  = mkv(0, 32'h10, 32'h12345678, 2, 1, 32'h12345678, 4, 2, 3);
        vecs[6]  = mkv(1, 32'h23, 32'hAAAA5555, 0, 1, 32'h12345678, 2, 2, 3);
        vecs[7]  = mkv(0, 32'h23, 32'h0BADF00D, 1, 1, 32'h0BADF00D, 3, 2, 4);
        vecs[8]  = mkv(0, 32'h23, 32'h0,        0, 0, 32'h0BADF00D, 1, 3, 4);
        vecs[9]  = mkv(0, 32'h11, 32'h11111111, 2, 1, 32'h11111111, 4, 3, 5);
        vecs[10] = mkv(0, 32'h10, 32'h0,        0, 0, 32'h12345678, 1, 4, 5);
        vecs[11] = mkv(0, 32'h11, 32'h0,        0, 0, 32'h11111111, 1, 5, 5);
        vecs[12] = mkv(1, 32'h11, 32'h22222222, 1, 1, 32'h11111111, 3, 5, 5);
        vecs[13] = mkv(0, 32'h11, 32'h0,        0, 0, 32'h22222222, 1, 6, 5);

        rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset mem_req", 64'(mem_req), 64'd0);
        check("reset mem_we", 64'(mem_we), 64'd0);
        check("reset q", {32'd0, q}, 64'd0);
        check("reset mem_addr", {32'd0, mem_addr}, 64'd0);
        check("reset mem_wdata", {32'd0, mem_wdata}, 64'd0);
        check_cnt("reset", 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // Back-to-back hits, one accepted per cycle in the RESP state.
        @(posedge clk); #1;
        req = 1'b1; wr = 1'b0; addr = 32'h10;
        @(posedge clk); #1; addr = 32'h11;
        @(negedge clk);
        check("b2b0 resp", 64'(resp_valid), 64'd1);
        check("b2b0 q", {32'd0, q}, 64'h12345678);
        @(posedge clk); #1; addr = 32'h23;
        @(negedge clk);
        check("b2b1 resp", 64'(resp_valid), 64'd1);
        check("b2b1 q", {32'd0, q}, 64'h22222222);
        @(posedge clk); #1; req = 1'b0;
        @(negedge clk);
        check("b2b2 resp", 64'(resp_valid), 64'd1);
        check("b2b2 q", {32'd0, q}, 64'h0BADF00D);
        check("b2b2 mem_req", 64'(mem_req), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b end", 64'(resp_valid), 64'd0);

        // Write hit, then a read of the same address accepted in the write's RESP cycle.
        @(posedge clk); #1;
        req = 1'b1; wr = 1'b1; addr = 32'h23; data = 32'h77777777;
        @(posedge clk); #1; req = 1'b0;
        @(negedge clk);
        check("wr23 mem_req", 64'(mem_req), 64'd1);
        check("wr23 mem_we", 64'(mem_we), 64'd1);
        check("wr23 mem_wdata", {32'd0, mem_wdata}, 64'h77777777);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0; req = 1'b1; wr = 1'b0; addr = 32'h23;
        @(negedge clk);
        check("wr23 resp", 64'(resp_valid), 64'd1);
        check("wr23 busy", 64'(busy), 64'd0);
        @(posedge clk); #1; req = 1'b0;
        @(negedge clk);
        check("rd23 resp", 64'(resp_valid), 64'd1);
        check("rd23 q", {32'd0, q}, 64'h77777777);
        check("rd23 mem_req", 64'(mem_req), 64'd0);
        check_cnt("after b2b", 10, 5);

        // Stray ack while idle must be ignored.
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
        @(posedge clk); #1; mem_ack = 1'b0;
        @(negedge clk);
        check("stray ack resp", 64'(resp_valid), 64'd0);
        check("stray ack q", {32'd0, q}, 64'h77777777);

        // Requests while busy during a fill are dropped.
        pulses = 0; rises = 0; prev = 0; bad = 0; got_q = '0;
        @(posedge clk); #1;
        req = 1'b1; wr = 1'b0; addr = 32'h30;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0; req = 1'b0;
            if (c == 2) begin req = 1'b1; wr = 1'b1; addr = 32'h11; data = 32'h99; end
            if (c == 3) begin req = 1'b1; wr = 1'b0; addr = 32'h23; end
            @(negedge clk);
            if (mem_req && !prev) rises++;
            prev = mem_req;
            if (mem_req && (mem_addr !== 32'h30 || mem_we !== 1'b0)) bad = 1;
            if (mem_req && c == 5) begin mem_ack = 1'b1; mem_rdata = 32'h30303030; end
            if (resp_valid) begin pulses++; got_q = q; end
        end
        check("busy ignore pulses", 64'(pulses), 64'd1);
        check("busy ignore mem_req rises", 64'(rises), 64'd1);
        check("busy ignore mem stable", 64'(bad), 64'd0);
        check("busy ignore q", {32'd0, got_q}, 64'h30303030);
        check_cnt("busy ignore", 10, 6);
        run_txn(mkv(0, 32'h11, 32'h0, 0, 0, 32'h22222222, 1, 11, 6), "line1 intact");

        // Reset mid-fill: mem_req drops asynchronously, no response, all lines invalid.
        @(posedge clk); #1;
        req = 1'b1; wr = 1'b0; addr = 32'h31;
        @(posedge clk); #1; req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midfill mem_req before", 64'(mem_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midfill mem_req async", 64'(mem_req), 64'd0);
        check("midfill busy async", 64'(busy), 64'd0);
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("midfill no resp", 64'(pulses), 64'd0);
        check("midfill q", {32'd0, q}, 64'd0);
        check_cnt("midfill", 0, 0);
        run_txn(mkv(0, 32'h11, 32'h44444444, 1, 1, 32'h44444444, 3, 0, 1), "post reset");
        run_txn(mkv(0, 32'h10, 32'h55555555, 2, 1, 32'h55555555, 4, 0, 2), "post reset 10");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Parametrised direct-mapped, write-through, read-allocate cache controller. It sits between a single requester and a slower word-addressed backing memory, and talks to that memory over a req/ack handshake. Compared with the fixed 4-line predecessor, it adds:
- parametrised geometry;
- an explicit busy/response handshake instead of fixed delays;
- an update-on-write-hit policy;
- asynchronous reset of all valid state.

Parameters:
- ADDR_W, 32: word-address width.
- DATA_W, 32: data word width.
- LINES, 4: number of cache lines, one word each. Must be a power of 2, and at least 2.
- IDX_W, $clog2(LINES): index width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  request strobe; sampled only when busy=0.
- wr  in  1  1=write, 0=read; qualified by req.
- addr  in  ADDR_W  word address.
- data  in  DATA_W  write data.
- busy  out  1  high while a request is in flight.
- resp_valid  out  1  one-cycle pulse marking request completion.
- q  out  DATA_W  read data; valid when resp_valid=1, holds its value otherwise.
- mem_req  out  1  backing-memory request; held high until ack.
- mem_we  out  1  backing-memory write enable.
- mem_addr  out  ADDR_W  backing-memory address.
- mem_wdata  out  DATA_W  backing-memory write data.
- mem_ack  in  1  one-cycle completion from memory; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  backing-memory read data.
- hit_cnt  out  32  read-hit count (optional feature).
- miss_cnt  out  32  read-miss count (optional feature).

Behaviour:
- Address split: index = addr[IDX_W-1:0]; tag = addr[ADDR_W-1:IDX_W]. Per line: valid bit, tag, data word.
- Reset (rst_n=0, asynchronous):
  - all valid bits = 0; state = IDLE;
  - busy, resp_valid, mem_req, mem_we = 0;
  - q, mem_addr, mem_wdata, hit_cnt, miss_cnt = 0.
  - Tag and data arrays need no reset.
  - Reset during FILL or WRITE abandons the transaction: mem_req drops immediately, and no response is ever issued.
- The request is latched (wr, addr, data) on the rising edge where req=1 and state=IDLE. A req while busy=1 is ignored, not queued.
- States: IDLE, FILL, WRITE, RESP.
- IDLE, read hit (valid[index] and tag match) → RESP.
  - q = line data, resp_valid=1 in the next cycle.
  - Latency: 1 cycle. busy stays 0 throughout.
- IDLE, read miss → FILL.
  - busy=1, mem_req=1, mem_we=0, mem_addr=addr.
- FILL, on mem_ack=1:
  - line[index] ← {valid=1, tag, mem_rdata};
  - q ← mem_rdata; mem_req=0;
  - → RESP.
  - Latency: N+2 cycles, where mem_ack arrives N cycles after mem_req rises.
- IDLE, any write → WRITE.
  - busy=1, mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=data.
- WRITE, on mem_ack=1:
  - If the line hits, its data is updated to the written data. The tag is unchanged.
  - On a miss, no allocation: the line is untouched.
  - mem_req=0, mem_we=0; → RESP.
  - q is unchanged on writes.
- RESP: resp_valid=1 for exactly one cycle, busy=0, → IDLE. A new req is accepted in the RESP cycle, which allows back-to-back hits at 1 request/cycle.
- busy = (state==FILL or state==WRITE).
- mem_addr, mem_we and mem_wdata are stable for the whole time mem_req=1.
- mem_ack received outside FILL/WRITE is ignored.
- Index aliasing: a read miss to the same index as a valid line evicts it without writeback. This is safe because the cache is write-through.
- The hit check uses registered array contents. A read accepted in the RESP cycle of a write to the same address sees the updated data.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - hit_cnt increments on each read hit, and miss_cnt on each read miss, at the acceptance edge.
  - Writes are not counted.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: hit_cnt and miss_cnt are tied to 0, and no counter flops exist.

Test Plan:
1. Reset, then read addr 0x10 with memory returning 0xDEADBEEF after 3 cycles → mem_req high for 3 cycles with mem_addr=0x10; resp_valid 5 cycles after the request; q=0xDEADBEEF; miss_cnt=1.
2. Repeat the read of 0x10 → resp_valid the next cycle, q=0xDEADBEEF, no mem_req; hit_cnt=1.
3. Write 0x12345678 to 0x10, then read 0x10 → mem_we=1, mem_wdata=0x12345678; the following read hits with q=0x12345678 and no mem_req.
4. Read 0x14 (same index as 0x10 for LINES=4) → miss, line evicted; a later read of 0x10 misses again and mem_req rises.
5. Assert req twice while busy=1 during a fill → both ignored; exactly one resp_valid pulse; no second mem_req.
6. Drop rst_n mid-FILL, then release it and read 0x10 → mem_req falls asynchronously with no resp_valid; the post-reset read misses because all lines are invalid.
